q1_2_clk_div: RTL and testbench

Toggle-flip-flop clock divider. Produces a divided, 50 %-duty-cycle output `clk2` from the system clock `clk`, plus single-cycle rise/fall strobes. With default parameters and `en` tied high, `clk2` toggles on every `clk` rising edge, giving exactly half the input frequency (20 ns `clk` → 40 ns `clk2`). It sits at the clock-generation edge of the design and feeds slower logic or lab I/O; `clk2` is a registered signal and is not a global clock-tree buffer.

---
 rtl/q1_2_clk_div.sv | 56 +++++
 tb/tb_q1_2_clk_div.sv | 130 +++++++++++++
 2 files changed

// File: rtl/q1_2_clk_div.sv
// Toggle-flip-flop clock divider: clk2 flips every HALF_PERIOD enabled clk edges,
// with registered one-cycle rise/fall strobes aligned to the new clk2 level.
module q1_2_clk_div #(
  parameter int HALF_PERIOD = 1,
  parameter int CNT_WIDTH   = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic clk2,
  output logic rise,
  output logic fall
);

  generate
    if (HALF_PERIOD < 1) begin : g_bad_half_period
      $error("q1_2_clk_div: HALF_PERIOD must be >= 1");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(HALF_PERIOD - 1);

  // Power-up values of zero let the divider run without ever seeing a reset.
  logic [CNT_WIDTH-1:0] r_cnt  = '0;
  logic                 r_clk2 = 1'b0;
  logic                 r_rise = 1'b0;
  logic                 r_fall = 1'b0;
  logic                 w_toggle;

  always_comb begin
    w_toggle = en && (r_cnt == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_clk2 <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_toggle & ~r_clk2;
      r_fall <= w_toggle &  r_clk2;
      if (w_toggle) begin
        r_cnt  <= '0;
        r_clk2 <= ~r_clk2;
      end else if (en) begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign clk2 = r_clk2;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: tb/tb_q1_2_clk_div.sv
// Self-checking bench for q1_2_clk_div: a default (divide-by-2) and a HALF_PERIOD=3
// instance share rst/en, checked against a hand-written table and an edge-count model.
module tb_q1_2_clk_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  logic clk2A, riseA, fallA;
  logic clk2B, riseB, fallB;

  int checkCount = 0;
  int passCount  = 0;

  // Reference state: number of enabled, non-reset edges since the last reset.
  int nA = 0;
  int nB = 0;
  logic [2:0] expA = 3'b000;
  logic [2:0] expB = 3'b000;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] exp;
  } vector_t;

  vector_t vecs[$];

  always #10 clk = ~clk;

  q1_2_clk_div u_divA (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clk2(clk2A),
    .rise(riseA),
    .fall(fallA)
  );

  q1_2_clk_div #(.HALF_PERIOD(3)) u_divB (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clk2(clk2B),
    .rise(riseB),
    .fall(fallB)
  );

  // Expected {clk2, rise, fall} after an edge, from the enabled-edge count alone.
  function automatic logic [2:0] modelOut(input int hp, input int n, input logic stepped);
    logic lvl;
    logic edgeHit;
    lvl     = ((n / hp) % 2) == 1;
    edgeHit = stepped && (n > 0) && ((n % hp) == 0);
    return {lvl, edgeHit & lvl, edgeHit & ~lvl};
  endfunction

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got {clk2,rise,fall}=%b expected %b at %0t", name, actual, expected, $time);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare both DUTs.
  task automatic applyStimulus(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) begin
      nA = 0; nB = 0;
      expA = 3'b000; expB = 3'b000;
    end else begin
      if (e) begin nA++; nB++; end
      expA = modelOut(1, nA, e);
      expB = modelOut(3, nB, e);
    end
    #1;
    checkOutput("modelA", {clk2A, riseA, fallA}, expA);
    checkOutput("modelB", {clk2B, riseB, fallB}, expB);
  endtask

  function automatic vector_t mk(input logic r, input logic e, input logic [2:0] x);
    vector_t v;
    v.rst = r; v.en = e; v.exp = x;
    return v;
  endfunction

  initial begin
    // HALF_PERIOD=3 hand-derived sequence: reset, full period, en stall, mid-period reset, en=0 with rst toggling.
    vecs.push_back(mk(1, 1, 3'b000)); vecs.push_back(mk(1, 1, 3'b000));
    vecs.push_back(mk(0, 1, 3'b000)); vecs.push_back(mk(0, 1, 3'b000));
    vecs.push_back(mk(0, 1, 3'b110)); vecs.push_back(mk(0, 1, 3'b100));
    vecs.push_back(mk(0, 1, 3'b100)); vecs.push_back(mk(0, 1, 3'b001));
    vecs.push_back(mk(0, 1, 3'b000));
    vecs.push_back(mk(0, 0, 3'b000)); vecs.push_back(mk(0, 0, 3'b000));
    vecs.push_back(mk(0, 0, 3'b000)); vecs.push_back(mk(0, 0, 3'b000));
    vecs.push_back(mk(0, 1, 3'b000)); vecs.push_back(mk(0, 1, 3'b110));
    vecs.push_back(mk(0, 1, 3'b100));
    vecs.push_back(mk(1, 1, 3'b000));
    vecs.push_back(mk(0, 1, 3'b000)); vecs.push_back(mk(0, 1, 3'b000));
    vecs.push_back(mk(0, 1, 3'b110)); vecs.push_back(mk(0, 1, 3'b100));
    vecs.push_back(mk(1, 0, 3'b000)); vecs.push_back(mk(0, 0, 3'b000));
    vecs.push_back(mk(1, 0, 3'b000)); vecs.push_back(mk(0, 0, 3'b000));
    vecs.push_back(mk(0, 0, 3'b000));

    // Power-up without reset: both outputs start low.
    #1;
    checkOutput("powerupA", {clk2A, riseA, fallA}, 3'b000);
    checkOutput("powerupB", {clk2B, riseB, fallB}, 3'b000);

    // No reset, en high from time 0: default divider toggles on every edge.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("noResetA", {clk2A, riseA, fallA}, (i % 2 == 0) ? 3'b110 : 3'b001);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en);
      checkOutput($sformatf("tableB[%0d]", i), {clk2B, riseB, fallB}, vecs[i].exp);
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 16) == 0, ($urandom % 4) != 0);
      checkOutput("neverBoth", {1'b0, riseA & fallA, riseB & fallB}, 3'b000);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
